// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Definitions shared by the entropy scheduler and its sub-modules.
//   WORD_W                  : width of one conditioner word
//   DEFAULT_WORDS_PER_BLOCK : words in one conditioner block (8 x 32 = 256 bits)
//   state_t                 : scheduler FSM state encoding
// -----------------------------------------------------------------------------
package trng_pkg;

    localparam int WORD_W                  = 32;
    localparam int DEFAULT_WORDS_PER_BLOCK = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_PUSH    = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first set bit of i_mask
// strictly after i_last, wrapping from N-1 back to 0. If only i_last itself
// is set, i_last is returned.
//   i_mask : candidate mask (N bits)
//   i_last : index used last time
//   o_next : next index to use (meaningful only when o_any = 1)
//   o_any  : at least one bit of i_mask is set
// N must be a power of two so that index arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter  int N  = 32,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_next,
    output logic          o_any
);

    always_comb begin
        logic [IW-1:0] v_idx;
        logic          v_found;
        // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
        o_next  = i_last;
        v_found = 1'b0;
        v_idx   = '0;
        // Offsets 1..N; the IW-bit sum wraps modulo N, and offset N lands back on i_last.
        for (int k = 1; k <= N; k++) begin
            v_idx = i_last + IW'(k);
            if (!v_found && i_mask[v_idx]) begin
                o_next  = v_idx;
                v_found = 1'b1;
            end
        end
    end

    assign o_any = |i_mask;

endmodule

// File: rtl/entropy_scheduler.sv
// -----------------------------------------------------------------------------
// entropy_scheduler
// Rotates through healthy entropy sources, assembles 32-bit words from their
// serial bits and hands them to the conditioner in blocks of WORDS_PER_BLOCK.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : run request (honoured only at block boundaries)
//   temp_ok        : all temperature sensors good
//   src_good       : per-source online health test pass flags
//   src_bit(_valid): serial bit from the selected source and its qualifier
//   src_sel        : entropy mux select
//   cond_word/valid/last/ready : word handshake to the conditioner
//   cond_abort     : one-cycle pulse, discard the partial block
//   fault          : no usable source or temperature bad
//   blocks_done    : completed blocks, saturating
// -----------------------------------------------------------------------------
module entropy_scheduler
    import trng_pkg::*;
#(
    parameter  int NUM_SRC         = 32,
    parameter  int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
    localparam int SEL_W           = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               temp_ok,
    input  logic [NUM_SRC-1:0] src_good,
    input  logic               src_bit,
    input  logic               src_bit_valid,
    output logic [SEL_W-1:0]   src_sel,
    output logic [WORD_W-1:0]  cond_word,
    output logic               cond_valid,
    output logic               cond_last,
    input  logic               cond_ready,
    output logic               cond_abort,
    output logic               fault,
    output logic [15:0]        blocks_done
);

    localparam int               WC_W      = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int               BC_W      = $clog2(WORD_W);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WORDS_PER_BLOCK - 1);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(WORD_W - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_src_sel;
    logic [SEL_W-1:0]    r_last_idx;
    logic [WORD_W-1:0]   r_word;
    logic [BC_W-1:0]     r_bit_cnt;
    logic [WC_W-1:0]     r_word_cnt;
    logic [15:0]         r_blocks_done;

    logic [SEL_W-1:0]    w_pick;
    logic                w_any;
    logic                w_run_ok;
    logic                w_src_bad;
    logic                w_last_word;
    logic                w_abort;
    logic                w_shift;
    logic                w_push_ok;
    logic                w_load_sel;

    rr_picker #(.N(NUM_SRC)) u_rr_picker (
        .i_mask (src_good),
        .i_last (r_last_idx),
        .o_next (w_pick),
        .o_any  (w_any)
    );

    assign w_run_ok    = temp_ok && w_any;
    // Health of the source currently feeding the word; checked only while a word is live.
    assign w_src_bad   = !src_good[r_src_sel] || !temp_ok;
    assign w_last_word = (r_word_cnt == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_shift     = 1'b0;
        w_push_ok   = 1'b0;
        w_load_sel  = 1'b0;
        cond_valid  = 1'b0;
        cond_last   = 1'b0;
        fault       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = w_run_ok ? ST_SELECT : ST_FAULT;
                end
            end

            ST_SELECT: begin
                // Reached at a block boundary with enable low (e.g. after an abort): do not start a new block.
                if (r_word_cnt == '0 && !enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_run_ok) begin
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_load_sel  = 1'b1;
                    w_state_nxt = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                if (w_src_bad) begin
                    w_abort     = 1'b1;
                    w_state_nxt = w_run_ok ? ST_SELECT : ST_FAULT;
                end else if (src_bit_valid) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end

            ST_PUSH: begin
                cond_valid = 1'b1;
                cond_last  = w_last_word;
                // Abort outranks a simultaneous handshake: the word is not counted.
                if (w_src_bad) begin
                    w_abort     = 1'b1;
                    w_state_nxt = w_run_ok ? ST_SELECT : ST_FAULT;
                end else if (cond_ready) begin
                    w_push_ok   = 1'b1;
                    w_state_nxt = (w_last_word && !enable) ? ST_IDLE : ST_SELECT;
                end
            end

            ST_FAULT: begin
                fault = 1'b1;
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_run_ok) begin
                    w_state_nxt = ST_SELECT;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_sel     <= '0;
            r_last_idx    <= SEL_W'(NUM_SRC - 1);
            r_word        <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_blocks_done <= '0;
        end else begin
            if (w_load_sel) begin
                r_src_sel  <= w_pick;
                r_last_idx <= w_pick;
            end

            if (w_abort) begin
                r_word     <= '0;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
            end else begin
                if (w_shift) begin
                    r_word    <= {r_word[WORD_W-2:0], src_bit};
                    r_bit_cnt <= r_bit_cnt + BC_W'(1);   // wraps to 0 after the last bit
                end
                if (w_push_ok) begin
                    if (w_last_word) begin
                        r_word_cnt <= '0;
                        if (r_blocks_done != 16'hFFFF) begin
                            r_blocks_done <= r_blocks_done + 16'd1;
                        end
                    end else begin
                        r_word_cnt <= r_word_cnt + WC_W'(1);
                    end
                end
            end
        end
    end

    assign src_sel     = r_src_sel;
    assign cond_word   = r_word;
    assign cond_abort  = w_abort;
    assign blocks_done = r_blocks_done;

endmodule

// File: tb/tb_entropy_scheduler.sv
// -----------------------------------------------------------------------------
// tb_entropy_scheduler
// Self-checking bench for entropy_scheduler. A behavioural model tracks the
// last used source, the word index within the block and the block count;
// random data words and random idle gaps are fed serially.
// -----------------------------------------------------------------------------
module tb_entropy_scheduler;

    localparam int NUM_SRC = 32;
    localparam int WPB     = 8;
    localparam int SEL_W   = $clog2(NUM_SRC);

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               temp_ok;
    logic [NUM_SRC-1:0] src_good;
    logic               src_bit;
    logic               src_bit_valid;
    logic [SEL_W-1:0]   src_sel;
    logic [31:0]        cond_word;
    logic               cond_valid;
    logic               cond_last;
    logic               cond_ready;
    logic               cond_abort;
    logic               fault;
    logic [15:0]        blocks_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_last;
    int m_word;
    int m_blocks;

    entropy_scheduler #(
        .NUM_SRC         (NUM_SRC),
        .WORDS_PER_BLOCK (WPB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .temp_ok       (temp_ok),
        .src_good      (src_good),
        .src_bit       (src_bit),
        .src_bit_valid (src_bit_valid),
        .src_sel       (src_sel),
        .cond_word     (cond_word),
        .cond_valid    (cond_valid),
        .cond_last     (cond_last),
        .cond_ready    (cond_ready),
        .cond_abort    (cond_abort),
        .fault         (fault),
        .blocks_done   (blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next healthy source strictly after 'last', scanning upward with wrap.
    function automatic int pick(input logic [NUM_SRC-1:0] mask, input int last);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (mask[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; temp_ok = 1'b1; src_good = '1;
        src_bit = 1'b0; src_bit_valid = 1'b0; cond_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        m_last = NUM_SRC - 1; m_word = 0; m_blocks = 0;
    endtask

    // Called with the DUT in SELECT; returns with it in PUSH.
    task automatic collect_word(input logic [31:0] data);
        logic [SEL_W-1:0] exp_sel;
        logic             exp_last;
        tick();
        m_last  = pick(src_good, m_last);
        exp_sel = SEL_W'(m_last);
        checks++; if (src_sel !== exp_sel) begin errors++; $display("FAIL select: src_sel=%0d want %0d", src_sel, exp_sel); end
        for (int i = 0; i < 32; i++) begin
            repeat ($urandom_range(0, 2)) begin
                src_bit_valid = 1'b0; src_bit = 1'($urandom); tick();
            end
            src_bit_valid = 1'b1; src_bit = data[31-i]; tick();
        end
        src_bit_valid = 1'b0;
        exp_last = (m_word == WPB - 1);
        checks++; if (cond_valid !== 1'b1) begin errors++; $display("FAIL push_valid: cond_valid=%b want 1", cond_valid); end
        checks++; if (cond_word !== data) begin errors++; $display("FAIL word: cond_word=%h want %h", cond_word, data); end
        checks++; if (cond_last !== exp_last) begin errors++; $display("FAIL last: cond_last=%b want %b (word %0d)", cond_last, exp_last, m_word); end
    endtask

    // Called with the DUT in PUSH; stalls, then completes the handshake.
    task automatic finish_word(input logic [31:0] data, input int stall);
        cond_ready = 1'b0;
        repeat (stall) begin
            src_bit_valid = 1'($urandom); src_bit = 1'($urandom); tick();
        end
        if (stall > 0) begin
            checks++; if (cond_word !== data || cond_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold: cond_word=%h valid=%b want %h valid=1", cond_word, cond_valid, data);
            end
        end
        src_bit_valid = 1'($urandom); src_bit = 1'($urandom); cond_ready = 1'b1;
        tick();
        cond_ready = 1'b0; src_bit_valid = 1'b0;
        if (m_word == WPB - 1) begin
            m_word = 0;
            if (m_blocks < 16'hFFFF) m_blocks++;
        end else begin
            m_word++;
        end
        checks++; if (blocks_done !== 16'(m_blocks)) begin errors++; $display("FAIL blocks: blocks_done=%0d want %0d", blocks_done, m_blocks); end
        checks++; if (cond_valid !== 1'b0) begin errors++; $display("FAIL post_push_valid: cond_valid=%b want 0", cond_valid); end
    endtask

    task automatic run_word(input int stall);
        logic [31:0] data;
        data = $urandom;
        collect_word(data);
        finish_word(data, stall);
    endtask

    // Select a source and shift a few bits, leaving the DUT in COLLECT.
    task automatic partial_word(input int nbits);
        tick();
        m_last = pick(src_good, m_last);
        for (int i = 0; i < nbits; i++) begin
            src_bit_valid = 1'b1; src_bit = 1'($urandom); tick();
        end
        src_bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; temp_ok = 1'b1; src_good = '1;
        src_bit = 1'b0; src_bit_valid = 1'b0; cond_ready = 1'b0;
        repeat (2) tick();
        checks++; if (src_sel !== '0) begin errors++; $display("FAIL rst_sel: got %0d want 0", src_sel); end
        checks++; if (cond_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h want 0", cond_word); end
        checks++; if (cond_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", cond_valid); end
        checks++; if (cond_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", cond_last); end
        checks++; if (cond_abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b want 0", cond_abort); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault); end
        checks++; if (blocks_done !== 16'h0) begin errors++; $display("FAIL rst_blocks: got %0d want 0", blocks_done); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rotation();
        do_reset();
        enable = 1'b1;
        tick();
        checks++; if (cond_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL select_idle: valid=%b fault=%b want 0 0", cond_valid, fault); end
        for (int w = 0; w < WPB; w++) run_word(0);
        checks++; if (blocks_done !== 16'd1) begin errors++; $display("FAIL one_block: blocks_done=%0d want 1", blocks_done); end
    endtask

    task automatic test_sparse_mask();
        do_reset();
        src_good = 32'h0000_0011;
        enable   = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) run_word(0);
        src_good = 32'h8000_0001;
        for (int w = 0; w < 2; w++) run_word(0);
        checks++; if (src_sel !== 5'd0) begin errors++; $display("FAIL wrap: src_sel=%0d want 0", src_sel); end
    endtask

    task automatic test_abort();
        do_reset();
        enable = 1'b1;
        tick();
        for (int w = 0; w < 3; w++) run_word(0);
        partial_word(10);
        src_good         = '1;
        src_good[m_last] = 1'b0;
        src_bit_valid    = 1'b1; src_bit = 1'b1;
        #1;
        checks++; if (cond_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: cond_abort=%b want 1", cond_abort); end
        tick();
        src_bit_valid = 1'b0;
        m_word = 0;
        checks++; if (cond_abort !== 1'b0) begin errors++; $display("FAIL abort_once: cond_abort=%b want 0", cond_abort); end
        checks++; if (cond_word !== 32'h0) begin errors++; $display("FAIL abort_clear: cond_word=%h want 0", cond_word); end
        for (int w = 0; w < WPB; w++) run_word(0);
        checks++; if (blocks_done !== 16'd1) begin errors++; $display("FAIL abort_block: blocks_done=%0d want 1", blocks_done); end
    endtask

    task automatic test_fault();
        do_reset();
        temp_ok = 1'b0; enable = 1'b1;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL idle_fault: fault=%b want 1", fault); end
        enable = 1'b0;
        tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_idle: fault=%b want 0", fault); end
        temp_ok = 1'b1; enable = 1'b1;
        tick();
        partial_word(5);
        temp_ok = 1'b0; src_good = '0;
        #1;
        checks++; if (cond_abort !== 1'b1) begin errors++; $display("FAIL temp_abort: cond_abort=%b want 1", cond_abort); end
        tick();
        m_word = 0;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set: fault=%b want 1", fault); end
        repeat (3) tick();
        temp_ok = 1'b1;
        tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_hold: fault=%b want 1", fault); end
        src_good = '1;
        tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: fault=%b want 0", fault); end
        run_word(0);
    endtask

    task automatic test_back_pressure();
        logic [31:0] data;
        do_reset();
        enable = 1'b1;
        tick();
        run_word(20);
        for (int w = 1; w < WPB - 1; w++) run_word($urandom_range(0, 3));
        data = $urandom;
        collect_word(data);
        cond_ready       = 1'b1;
        src_good[m_last] = 1'b0;
        #1;
        checks++; if (cond_abort !== 1'b1) begin errors++; $display("FAIL push_abort: cond_abort=%b want 1", cond_abort); end
        tick();
        cond_ready = 1'b0;
        m_word = 0;
        checks++; if (blocks_done !== 16'd0) begin errors++; $display("FAIL abort_wins: blocks_done=%0d want 0", blocks_done); end
        checks++; if (cond_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: cond_valid=%b want 0", cond_valid); end
        run_word(0);
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        tick();
        run_word(0);
        enable = 1'b0;
        for (int w = 1; w < WPB; w++) run_word($urandom_range(0, 2));
        checks++; if (blocks_done !== 16'd1) begin errors++; $display("FAIL drain_block: blocks_done=%0d want 1", blocks_done); end
        src_bit_valid = 1'b1;
        repeat (4) tick();
        src_bit_valid = 1'b0;
        checks++; if (cond_valid !== 1'b0 || src_sel !== 5'd7) begin errors++; $display("FAIL idle_stay: valid=%b sel=%0d want 0 7", cond_valid, src_sel); end
        enable = 1'b1;
        tick();
        run_word(0);
        checks++; if (src_sel !== 5'd8) begin errors++; $display("FAIL restart_sel: src_sel=%0d want 8", src_sel); end
    endtask

    task automatic test_reset_midblock();
        do_reset();
        enable = 1'b1;
        tick();
        run_word(0);
        run_word(0);
        partial_word(12);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (src_sel !== '0 || cond_word !== 32'h0) begin errors++; $display("FAIL mid_rst_data: sel=%0d word=%h want 0 0", src_sel, cond_word); end
        checks++; if (cond_abort !== 1'b0) begin errors++; $display("FAIL mid_rst_abort: cond_abort=%b want 0", cond_abort); end
        checks++; if (blocks_done !== 16'h0 || cond_valid !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ctrl: blocks=%0d valid=%b fault=%b want 0 0 0", blocks_done, cond_valid, fault);
        end
        tick();
        checks++; if (cond_abort !== 1'b0) begin errors++; $display("FAIL mid_rst_abort2: cond_abort=%b want 0", cond_abort); end
        rst_n = 1'b1;
        m_last = NUM_SRC - 1; m_word = 0; m_blocks = 0;
        tick();
        run_word(0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; temp_ok = 1'b1; src_good = '1;
        src_bit = 1'b0; src_bit_valid = 1'b0; cond_ready = 1'b0;
        m_last = NUM_SRC - 1; m_word = 0; m_blocks = 0;
        test_reset();
        test_rotation();
        test_sparse_mask();
        test_abort();
        test_fault();
        test_back_pressure();
        test_enable_drop();
        test_reset_midblock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/entropy_scheduler.md
ENTROPY_SCHEDULER -- requirements
Module: entropy_scheduler

Interface
REQ-001 Parameter: NUM_SRC, 32, number of entropy sources (latch/jitter mux inputs); legal values are powers of 2, 2..64.
REQ-002 Parameter: WORDS_PER_BLOCK, 8, number of 32-bit words in one conditioner block (256 bits).
REQ-003 Port: clk  in  1  system clock; one clock domain only.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: enable  in  1  run request from the SPI control register.
REQ-006 Port: temp_ok  in  1  AND of all temp_sense_N_good.
REQ-007 Port: src_good  in  NUM_SRC  per-source online health test (OHT) pass flags.
REQ-008 Port: src_bit, src_bit_valid  in  1 each  serial bit from the selected source and its qualifier.
REQ-009 Port: src_sel  out  log2(NUM_SRC)  entropy mux select.
REQ-010 Port: cond_word  out  32  assembled word to the conditioner.
REQ-011 Port: cond_valid, cond_last  out  1 each  word valid; last word of the block.
REQ-012 Port: cond_ready  in  1  conditioner accepts the word.
REQ-013 Port: cond_abort  out  1  one-cycle pulse: discard the partial block.
REQ-014 Port: fault  out  1  no usable source, or temperature bad.
REQ-015 Port: blocks_done  out  16  count of completed blocks; saturates at 0xFFFF.

Function
REQ-016 The FSM shall have exactly these states: IDLE, SELECT, COLLECT, PUSH, FAULT.
REQ-017 IDLE shall go to SELECT when enable=1 && temp_ok=1 && |src_good; it shall go to FAULT when enable=1 and that condition fails; otherwise it shall stay in IDLE.
REQ-018 SELECT shall last 1 cycle and set src_sel to the next good index after the last used index, round-robin with wrap NUM_SRC-1 to 0; the first selection after reset shall start at index 0; the FSM shall then go to COLLECT.
REQ-019 COLLECT shall shift src_bit in MSB-first on each cycle with src_bit_valid=1; after the 32nd bit the FSM shall go to PUSH on the next cycle.
REQ-020 PUSH shall drive cond_valid=1 and hold cond_word stable until cond_valid && cond_ready; src_bit_valid shall be ignored during PUSH.
REQ-021 cond_last shall be 1 only during the PUSH of word index WORDS_PER_BLOCK-1.
REQ-022 On the PUSH handshake, the word counter shall increment; on the last word the counter shall wrap to 0 and blocks_done shall increment (saturating).
REQ-023 After a PUSH handshake, the FSM shall go to SELECT, so the source rotates every word; at a block boundary with enable=0 it shall go to IDLE instead.
REQ-024 enable=0 shall take effect only at a block boundary or in IDLE/FAULT; a block in progress shall complete.
REQ-025 Abort: if in COLLECT or PUSH src_good[src_sel]=0 or temp_ok=0, the FSM shall pulse cond_abort, clear the bit/word counters and the partial word, deassert cond_valid, and go to SELECT if temp_ok && |src_good, else to FAULT.
REQ-026 An abort and a PUSH handshake in the same cycle: the abort shall win and the word shall not count; src_bit_valid in the abort cycle shall be discarded.
REQ-027 FAULT shall hold fault=1 and go to SELECT when temp_ok && |src_good && enable, or to IDLE when enable=0; fault shall clear on exit.
REQ-028 The latency from a good condition in IDLE to the first COLLECT cycle shall be 2 clk cycles.

Reset
REQ-029 On rst_n=0 the block shall enter IDLE with src_sel=0, cond_word=0, cond_valid=0, cond_last=0, cond_abort=0, fault=0, blocks_done=0, all counters 0, and last-used index = NUM_SRC-1.
REQ-030 Reset asserted mid-block shall drop the block silently, with no cond_abort pulse.

Structure
REQ-031 A shared package trng_pkg shall hold the state enum, WORD_W=32 and the default WORDS_PER_BLOCK.
REQ-032 The round-robin search shall be a combinational sub-module rr_picker (inputs: mask, last index; outputs: next index, any).

Verification
REQ-033 src_good=all 1s, cond_ready=1, random bits -> src_sel sequence 0,1,2..7; cond_last on the 8th word; blocks_done=1.
REQ-034 src_good=32'h0000_0011 -> src_sel alternates 0,4,0,4; src_good=32'h8000_0001 after last index 31 -> wrap to 0.
REQ-035 src_good[sel] dropped after 10 bits of word 3 -> one cond_abort pulse, word counter 0, next src_sel = next good index.
REQ-036 temp_ok=0 mid-COLLECT with src_good=0 -> fault=1 in FAULT; restoring both -> SELECT, fault=0.
REQ-037 cond_ready held 0 for 20 cycles in PUSH -> cond_word stable, no bits consumed; ready=1 and abort in the same cycle -> no count.
REQ-038 enable=0 at word 2 -> words 3..8 still delivered, then IDLE; rst_n pulse mid-block -> all outputs at reset values and no abort.
